// File: rtl/omsp_atom_pkg.sv
// Shared types, defaults and helpers for the atomic-section scheduler.
package omsp_atom_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAtomic = 2'd1,
    StDrain  = 2'd2,
    StGuard  = 2'd3
  } atom_state_e;

  localparam int unsigned DefNumIrq      = 14;
  localparam int unsigned DefGuardCycles = 4;
  localparam int unsigned DefDeferCntW   = 8;

  // Widest counter the helper below can serve.
  localparam int unsigned SatMaxW = 32;

  function automatic logic [SatMaxW-1:0] sat_inc(input logic [SatMaxW-1:0] val,
                                                 input logic [SatMaxW-1:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/omsp_atom_sat_cnt.sv
// Saturating up-counter with synchronous clear and parallel load (clear > load > increment).
module omsp_atom_sat_cnt
  import omsp_atom_pkg::*;
#(
  parameter int unsigned W = DefDeferCntW
) (
  input  logic         mclk,
  input  logic         puc_rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MaxVal = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (inc) begin
      cnt_d = W'(sat_inc(SatMaxW'(cnt_q), SatMaxW'(MaxVal)));
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/omsp_atom_sched.sv
// Sequences clix atomic sections against interrupts so back-to-back sections cannot starve IRQs.
// Optional stats (max_defer, stats_clr) are built when ATOM_SCHED_STATS_EN is defined.
module omsp_atom_sched
  import omsp_atom_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = DefNumIrq,
  parameter int unsigned GUARD_CYCLES = DefGuardCycles,
  parameter int unsigned DEFER_CNT_W  = DefDeferCntW
) (
  input  logic                   mclk,
  input  logic                   puc_rst_n,
  input  logic                   clix_req,
  input  logic                   atom_active,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic [NUM_IRQ-1:0]     irq_ack,
  output logic                   clix_grant,
  output logic                   clix_stall,
  output logic [NUM_IRQ-1:0]     defer_mask,
  output logic [DEFER_CNT_W-1:0] defer_cycles,
  output logic [1:0]             sched_state
`ifdef ATOM_SCHED_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [DEFER_CNT_W-1:0] max_defer
`endif
);

  // Counter only needs to hold GUARD_CYCLES-1.
  localparam int unsigned GuardW = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GuardW-1:0] GuardLoad =
      (GUARD_CYCLES == 0) ? '0 : GuardW'(GUARD_CYCLES - 1);
  localparam bit HasGuard = (GUARD_CYCLES != 0);

  atom_state_e        state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [GuardW-1:0]  guard_q, guard_d;
  logic               dc_inc, dc_clr;

  assign clix_grant = clix_req & (state_q == StIdle) & ~(|irq_in) & ~(|mask_q);
  assign clix_stall = clix_req & ~clix_grant;

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    mask_d  = mask_q;
    if (state_q == StAtomic) begin
      mask_d = mask_d | irq_in;
    end
    // Ack after set so a same-cycle set and clear leaves the bit clear.
    mask_d = mask_d & ~irq_ack;

    case (state_q)
      StIdle: begin
        if (clix_grant || atom_active) begin
          state_d = StAtomic;
        end
      end
      StAtomic: begin
        if (!atom_active) begin
          if (mask_d != '0) begin
            state_d = StDrain;
          end else if (HasGuard) begin
            state_d = StGuard;
            guard_d = GuardLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        if (atom_active) begin
          state_d = StAtomic;
        end else if (mask_d == '0) begin
          if (HasGuard) begin
            state_d = StGuard;
            guard_d = GuardLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGuard: begin
        if (atom_active) begin
          state_d = StAtomic;
        end else if (guard_q == '0) begin
          state_d = StIdle;
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      guard_q <= guard_d;
    end
  end

  // The mask is only ever non-zero in ATOMIC/DRAIN, so it alone qualifies the count.
  assign dc_inc = (mask_q != '0);
  assign dc_clr = (state_d == StIdle) && (state_q != StIdle);

  omsp_atom_sat_cnt #(
    .W (DEFER_CNT_W)
  ) u_defer_cnt (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .clr       (dc_clr),
    .ld        (1'b0),
    .ld_val    ('0),
    .inc       (dc_inc),
    .cnt       (defer_cycles)
  );

`ifdef ATOM_SCHED_STATS_EN
  localparam logic [DEFER_CNT_W-1:0] DcMax = {DEFER_CNT_W{1'b1}};

  logic [DEFER_CNT_W-1:0] dc_upd;
  logic                   max_ld;

  // Episode length including this cycle's count, captured as the episode closes.
  assign dc_upd = dc_inc ? DEFER_CNT_W'(sat_inc(SatMaxW'(defer_cycles), SatMaxW'(DcMax)))
                         : defer_cycles;
  assign max_ld = dc_clr && (dc_upd > max_defer);

  omsp_atom_sat_cnt #(
    .W (DEFER_CNT_W)
  ) u_max_defer (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .clr       (stats_clr),
    .ld        (max_ld),
    .ld_val    (dc_upd),
    .inc       (1'b0),
    .cnt       (max_defer)
  );
`endif

  assign defer_mask  = mask_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_omsp_atom_sched.sv
// Directed table-driven bench for omsp_atom_sched; stats checks build with ATOM_SCHED_STATS_EN.
module tb_omsp_atom_sched;

  localparam int unsigned NI = 14;
  localparam int unsigned DW = 8;

  logic          mclk = 1'b0;
  logic          puc_rst_n;
  logic          clix_req;
  logic          atom_active;
  logic [NI-1:0] irq_in;
  logic [NI-1:0] irq_ack;
  logic          clix_grant;
  logic          clix_stall;
  logic [NI-1:0] defer_mask;
  logic [DW-1:0] defer_cycles;
  logic [1:0]    sched_state;
`ifdef ATOM_SCHED_STATS_EN
  logic          stats_clr;
  logic [DW-1:0] max_defer;
`endif

  always #5 mclk = ~mclk;

  omsp_atom_sched #(
    .NUM_IRQ      (NI),
    .GUARD_CYCLES (4),
    .DEFER_CNT_W  (DW)
  ) dut (
    .mclk         (mclk),
    .puc_rst_n    (puc_rst_n),
    .clix_req     (clix_req),
    .atom_active  (atom_active),
    .irq_in       (irq_in),
    .irq_ack      (irq_ack),
    .clix_grant   (clix_grant),
    .clix_stall   (clix_stall),
    .defer_mask   (defer_mask),
    .defer_cycles (defer_cycles),
    .sched_state  (sched_state)
`ifdef ATOM_SCHED_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .max_defer    (max_defer)
`endif
  );

  typedef struct {
    logic          cr;
    logic          aa;
    logic [NI-1:0] irq;
    logic [NI-1:0] ack;
    logic          g;
    logic          s;
    logic [1:0]    st;
    logic [NI-1:0] m;
    logic [DW-1:0] c;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input int cr, input int aa, input int irq, input int ack,
                              input int g, input int s, input int st, input int m, input int c);
    vec_t v;
    v.cr  = 1'(cr);
    v.aa  = 1'(aa);
    v.irq = NI'(irq);
    v.ack = NI'(ack);
    v.g   = 1'(g);
    v.s   = 1'(s);
    v.st  = 2'(st);
    v.m   = NI'(m);
    v.c   = DW'(c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs away from the edge, then advance a cycle.
  task automatic apply(input vec_t v, input string tag);
    clix_req    = v.cr;
    atom_active = v.aa;
    irq_in      = v.irq;
    irq_ack     = v.ack;
    #1;
    n_vec++;
    chk({tag, " grant"}, 32'(clix_grant), 32'(v.g));
    chk({tag, " stall"}, 32'(clix_stall), 32'(v.s));
    chk({tag, " state"}, 32'(sched_state), 32'(v.st));
    chk({tag, " mask"}, 32'(defer_mask), 32'(v.m));
    chk({tag, " cycles"}, 32'(defer_cycles), 32'(v.c));
    @(posedge mclk);
    @(negedge mclk);
  endtask

`ifdef ATOM_SCHED_STATS_EN
  task automatic episode(input int n);
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0), "ep grant");
    apply(mk(0, 1, 1, 0, 0, 0, 1, 0, 0), "ep irq");
    for (int i = 1; i < n; i++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 1, 1, i - 1), $sformatf("ep hold%0d", i));
    end
    apply(mk(0, 0, 0, 1, 0, 0, 1, 1, n - 1), "ep ack");
    for (int i = 0; i < 4; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 3, 0, n), $sformatf("ep guard%0d", i));
    end
  endtask
`endif

  vec_t tbl[23];

  initial begin
    tbl[0]  = mk(0, 0, 'h0,  'h0, 0, 0, 0, 'h0, 0);
    tbl[1]  = mk(1, 0, 'h10, 'h0, 0, 1, 0, 'h0, 0);
    tbl[2]  = mk(1, 0, 'h0,  'h0, 1, 0, 0, 'h0, 0);
    tbl[3]  = mk(0, 1, 'h2,  'h0, 0, 0, 1, 'h0, 0);
    tbl[4]  = mk(0, 1, 'h0,  'h0, 0, 0, 1, 'h2, 0);
    tbl[5]  = mk(0, 1, 'h0,  'h0, 0, 0, 1, 'h2, 1);
    tbl[6]  = mk(0, 1, 'h0,  'h0, 0, 0, 1, 'h2, 2);
    tbl[7]  = mk(0, 1, 'h0,  'h0, 0, 0, 1, 'h2, 3);
    tbl[8]  = mk(1, 0, 'h0,  'h0, 0, 1, 1, 'h2, 4);
    tbl[9]  = mk(1, 0, 'h0,  'h0, 0, 1, 2, 'h2, 5);
    tbl[10] = mk(1, 0, 'h0,  'h2, 0, 1, 2, 'h2, 6);
    tbl[11] = mk(1, 0, 'h0,  'h0, 0, 1, 3, 'h0, 7);
    tbl[12] = mk(1, 0, 'h0,  'h0, 0, 1, 3, 'h0, 7);
    tbl[13] = mk(1, 0, 'h0,  'h0, 0, 1, 3, 'h0, 7);
    tbl[14] = mk(1, 0, 'h0,  'h0, 0, 1, 3, 'h0, 7);
    tbl[15] = mk(1, 0, 'h0,  'h0, 1, 0, 0, 'h0, 0);
    tbl[16] = mk(0, 1, 'h8,  'h8, 0, 0, 1, 'h0, 0);
    tbl[17] = mk(0, 1, 'h1,  'h0, 0, 0, 1, 'h0, 0);
    tbl[18] = mk(0, 0, 'h0,  'h0, 0, 0, 1, 'h1, 0);
    tbl[19] = mk(0, 0, 'h0,  'h0, 0, 0, 2, 'h1, 1);
    tbl[20] = mk(0, 1, 'h0,  'h0, 0, 0, 2, 'h1, 2);
    tbl[21] = mk(0, 1, 'h0,  'h0, 0, 0, 1, 'h1, 3);
    tbl[22] = mk(0, 1, 'h0,  'h0, 0, 0, 1, 'h1, 4);

    puc_rst_n   = 1'b0;
    clix_req    = 1'b0;
    atom_active = 1'b0;
    irq_in      = '0;
    irq_ack     = '0;
`ifdef ATOM_SCHED_STATS_EN
    stats_clr   = 1'b0;
`endif
    #1;
    n_vec++;
    chk("por state", 32'(sched_state), 32'd0);
    chk("por mask", 32'(defer_mask), 32'd0);
    chk("por cycles", 32'(defer_cycles), 32'd0);
    chk("por grant", 32'(clix_grant), 32'd0);
    chk("por stall", 32'(clix_stall), 32'd0);
    @(negedge mclk);
    @(negedge mclk);
    puc_rst_n = 1'b1;
    @(negedge mclk);

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Hold the mask through a long SM-entry section to drive the counter into saturation.
    atom_active = 1'b1;
    irq_in      = '0;
    irq_ack     = '0;
    clix_req    = 1'b0;
    repeat (260) @(negedge mclk);
    apply(mk(0, 1, 0, 1, 0, 0, 1, 1, 255), "sat hold");
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0, 255), "sat fall");
    for (int i = 0; i < 4; i++) begin
      apply(mk(1, 0, 0, 0, 0, 1, 3, 0, 255), $sformatf("sat guard%0d", i));
    end
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0), "sat idle");

    // Park in DRAIN with bit 2 deferred, then reset asynchronously mid-cycle.
    apply(mk(0, 1, 'h4, 0, 0, 0, 1, 0, 0), "rst irq");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 'h4, 0), "rst fall");
    apply(mk(0, 0, 0, 0, 0, 0, 2, 'h4, 1), "rst drain");
    #2;
    puc_rst_n = 1'b0;
    #1;
    n_vec++;
    chk("async rst state", 32'(sched_state), 32'd0);
    chk("async rst mask", 32'(defer_mask), 32'd0);
    chk("async rst cycles", 32'(defer_cycles), 32'd0);
    chk("async rst grant", 32'(clix_grant), 32'd0);
    @(negedge mclk);
    #2;
    puc_rst_n = 1'b1;
    @(negedge mclk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "post rst");

`ifdef ATOM_SCHED_STATS_EN
    n_vec++;
    chk("max reset", 32'(max_defer), 32'd0);
    episode(7);
    n_vec++;
    chk("max after 7", 32'(max_defer), 32'd7);
    episode(3);
    n_vec++;
    chk("max after 3", 32'(max_defer), 32'd7);
    stats_clr = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    stats_clr = 1'b0;
    #1;
    n_vec++;
    chk("max cleared", 32'(max_defer), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/omsp_atom_sched.md
Name: omsp_atom_sched

Overview:
- Controller that sequences atomic sections against interrupt service.
- Sits between the core's clix decode, the atomicity monitor's "atomic section active" status and the interrupt request lines.
- Grants or stalls new clix sections, records which IRQs arrive while an atomic section masks them, and holds off further clix sections until those IRQs are acknowledged and a guard window has elapsed.
- Purpose: back-to-back atomic sections cannot starve interrupts indefinitely.

Parameters:
- NUM_IRQ, 14: number of maskable interrupt lines tracked.
- GUARD_CYCLES, 4: cycles clix stays stalled after the deferred IRQs drain; 0 skips the guard phase.
- DEFER_CNT_W, 8: width of the deferral-latency counter (saturating).

Ports:
- mclk  in  1  core clock.
- puc_rst_n  in  1  asynchronous reset, active-low.
- clix_req  in  1  clix instruction decoded and requesting start.
- atom_active  in  1  monitor reports clix or SM-entry atomic section in progress.
- irq_in  in  NUM_IRQ  raw interrupt requests.
- irq_ack  in  NUM_IRQ  one-hot core acceptance of an interrupt.
- clix_grant  out  1  combinational; clix may start this cycle.
- clix_stall  out  1  combinational; core must hold clix in execute.
- defer_mask  out  NUM_IRQ  IRQs that arrived during atomic sections and are not yet acked.
- defer_cycles  out  DEFER_CNT_W  cycles elapsed with defer_mask non-zero in the current episode.
- sched_state  out  2  encoded FSM state.

Behaviour:
- Reset (puc_rst_n low, asynchronous, any state): state=IDLE, defer_mask=0, defer_cycles=0, guard counter=0. Consequently clix_grant=0 and clix_stall=0.
- State encoding: IDLE=0, ATOMIC=1, DRAIN=2, GUARD=3.
- clix_grant = clix_req & (state==IDLE) & (irq_in==0) & (defer_mask==0).
- clix_stall = clix_req & ~clix_grant.
- IDLE:
  - clix_grant -> ATOMIC next cycle.
  - atom_active high (SM entry, not grantable) -> ATOMIC.
  - clix_req with irq_in non-zero -> stall; interrupt takes precedence and nothing is deferred in IDLE.
- ATOMIC:
  - defer_mask |= irq_in each cycle.
  - defer_cycles increments while defer_mask non-zero, saturating at all-ones.
  - atom_active low -> DRAIN if defer_mask (after this cycle's update) is non-zero, else GUARD; if GUARD_CYCLES==0, go to IDLE instead of GUARD.
- DRAIN:
  - defer_cycles keeps counting (saturating).
  - Leaves when defer_mask==0: to GUARD with counter=GUARD_CYCLES-1, or to IDLE if GUARD_CYCLES==0.
- GUARD:
  - Counter decrements; at 0 -> IDLE.
- Re-entry: atom_active high while in DRAIN or GUARD (SM entry cannot be stalled) -> ATOMIC; defer_mask and defer_cycles are retained.
- Clearing:
  - irq_ack clears the matching defer_mask bits in every state. Same-cycle set and clear of one bit: clear wins.
  - defer_cycles clears on every transition into IDLE.
- Latency: grant is same-cycle. State updates one cycle after the triggering input. Minimum stall after atom_active falls with an empty mask is GUARD_CYCLES.

Optional Feature:
- Macro: ATOM_SCHED_STATS_EN.
- Defined:
  - Adds output max_defer [DEFER_CNT_W-1:0], the high-water mark of defer_cycles, updated on each transition into IDLE.
  - Adds input stats_clr; a one-cycle pulse zeroes max_defer and takes priority over a same-cycle update.
  - Both are reset to 0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package omsp_atom_pkg:
  - State enum (IDLE/ATOMIC/DRAIN/GUARD) and its 2-bit encoding.
  - Default NUM_IRQ / GUARD_CYCLES / DEFER_CNT_W constants.
  - Saturating-increment function.
- One natural sub-module, omsp_atom_sat_cnt: a parameterised saturating up-counter with clear. It is used for defer_cycles and reused for max_defer tracking under ATOM_SCHED_STATS_EN.

Test Plan:
- Reset mid-DRAIN with defer_mask=0x0004: drop puc_rst_n -> immediately state=0, defer_mask=0, defer_cycles=0, clix_grant=0.
- IDLE, clix_req=1, irq_in=0 -> clix_grant=1 same cycle, state=ATOMIC next cycle. Repeat with irq_in=0x0010 -> clix_stall=1, defer_mask stays 0.
- ATOMIC, irq_in=0x0002 for one cycle, atom_active falls 5 cycles later -> defer_mask=0x0002, defer_cycles=5, state=DRAIN, clix_req stalled. irq_ack=0x0002 -> GUARD for 4 cycles, then IDLE with defer_cycles=0.
- Same-cycle irq_in=0x0008 and irq_ack=0x0008 in ATOMIC -> bit 3 of defer_mask stays 0.
- DRAIN with defer_mask=0x0001, atom_active rises (SM entry) -> ATOMIC with mask 0x0001 retained and defer_cycles still counting. DEFER_CNT_W=8 with a held mask -> defer_cycles saturates at 255.
- ATOM_SCHED_STATS_EN defined: two episodes of 7 and 3 deferred cycles -> max_defer=7; pulse stats_clr -> max_defer=0.
